inv_clarke: RTL and testbench

INV_CLARKE -- requirements
Module: inv_clarke

---
 rtl/inv_clarke_pkg.sv | 48 ++++
 rtl/inv_clarke_if.sv | 25 ++
 rtl/inv_clarke_sat.sv | 27 ++
 rtl/inv_clarke.sv | 157 +++++++++++++++
 tb/tb_inv_clarke.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/inv_clarke_pkg.sv
// Shared FOC constants, FSM state encodings and datapath types for the inverse Clarke transform.
// INV_CLARKE_ZSI_EN enables the min/max zero-sequence injection helper in use.
package inv_clarke_pkg;

   localparam int unsigned DW   = 16;   // Q15 sample width
   localparam int unsigned SW   = 18;   // headroom width for phase sums
   localparam int unsigned PW   = 32;   // full multiplier product width
   localparam int unsigned FRAC = 15;   // Q15 fractional bits

   localparam logic signed [DW-1:0] SQRT3_2_Q15 = 16'sd28378;
   localparam logic signed [DW-1:0] INVROOT3    = 16'sd18919;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_SUM  = 3'd2,
      ST_ZSI  = 3'd3,
      ST_OUT  = 3'd4
   } foc_state_e;

   typedef struct packed {
      logic signed [SW-1:0] va;
      logic signed [SW-1:0] vb;
      logic signed [SW-1:0] vc;
   } phase18_t;

   // Zero-sequence offset -((max + min) >>> 1) over three unsaturated phases.
   function automatic logic signed [SW-1:0] zs_offset(input phase18_t p);
      logic signed [SW:0] a;
      logic signed [SW:0] b;
      logic signed [SW:0] c;
      logic signed [SW:0] mx;
      logic signed [SW:0] mn;
      logic signed [SW:0] s;
      a  = (SW+1)'($signed(p.va));
      b  = (SW+1)'($signed(p.vb));
      c  = (SW+1)'($signed(p.vc));
      mx = a;
      mn = a;
      if (b > mx) mx = b;
      if (c > mx) mx = c;
      if (b < mn) mn = b;
      if (c < mn) mn = c;
      s  = mx + mn;
      return SW'(-(s >>> 1));
   endfunction

endpackage

// File: rtl/inv_clarke_if.sv
// Sample-in / phase-out bus of the inverse Clarke transform.
interface inv_clarke_if;
   import inv_clarke_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] alpha;
   logic signed [DW-1:0] beta;
   logic                 out_valid;
   logic signed [DW-1:0] va;
   logic signed [DW-1:0] vb;
   logic signed [DW-1:0] vc;
   logic                 sat;

   modport master (
      output in_valid, alpha, beta,
      input  in_ready, out_valid, va, vb, vc, sat
   );

   modport slave (
      input  in_valid, alpha, beta,
      output in_ready, out_valid, va, vb, vc, sat
   );

endinterface

// File: rtl/inv_clarke_sat.sv
// sat_s18_s16: combinational symmetric clip of an 18-bit signed value to 16 bits, with clip flag.
module sat_s18_s16
   import inv_clarke_pkg::*;
#(
   parameter int SAT_LIM = 32767
) (
   input  logic signed [SW-1:0] x,
   output logic signed [DW-1:0] y_c,
   output logic                 clip_c
);

   localparam logic signed [SW-1:0] POS_LIM = SW'(SAT_LIM);
   localparam logic signed [SW-1:0] NEG_LIM = SW'(-SAT_LIM);

   always_comb begin
      y_c    = DW'(x);
      clip_c = 1'b0;
      if (x > POS_LIM) begin
         y_c    = DW'(POS_LIM);
         clip_c = 1'b1;
      end else if (x < NEG_LIM) begin
         y_c    = DW'(NEG_LIM);
         clip_c = 1'b1;
      end
   end

endmodule

// File: rtl/inv_clarke.sv
// Inverse Clarke transform: alpha/beta (Q15) -> saturated three-phase va/vb/vc, one multiplier.
// Define INV_CLARKE_ZSI_EN to add min/max zero-sequence injection (one extra cycle of latency).
module inv_clarke
   import inv_clarke_pkg::*;
#(
   parameter int SAT_LIM = 32767
) (
   input  logic         clk,
   input  logic         rst_n,
   inv_clarke_if.slave  bus
);

   foc_state_e state_q;
   foc_state_e state_d;

   logic                 in_ready_q;
   logic                 accept_c;
   logic signed [DW-1:0] alpha_q;
   logic signed [DW-1:0] mul_a_q;
   logic signed [DW-1:0] mul_b_q;
   logic signed [PW-1:0] prod_q;
   phase18_t             sum_q;
   phase18_t             sum_c;
   logic signed [SW-1:0] half_c;
   logic signed [SW-1:0] m_c;

   logic signed [DW-1:0] va_q;
   logic signed [DW-1:0] vb_q;
   logic signed [DW-1:0] vc_q;
   logic                 sat_q;
   logic                 out_valid_q;

   logic signed [DW-1:0] va_c;
   logic signed [DW-1:0] vb_c;
   logic signed [DW-1:0] vc_c;
   logic [2:0]           clip_c;

   // in_ready_q mirrors "state is IDLE", so acceptance needs no state decode here.
   assign accept_c = in_ready_q & bus.in_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept_c) state_d = ST_MUL;
         ST_MUL:  state_d = ST_SUM;
`ifdef INV_CLARKE_ZSI_EN
         ST_SUM:  state_d = ST_ZSI;
         ST_ZSI:  state_d = ST_OUT;
`else
         ST_SUM:  state_d = ST_OUT;
`endif
         ST_OUT:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Operand capture on acceptance; beta feeds the multiplier directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alpha_q <= '0;
         mul_a_q <= '0;
         mul_b_q <= '0;
      end else if (accept_c) begin
         alpha_q <= bus.alpha;
         mul_a_q <= bus.beta;
         mul_b_q <= SQRT3_2_Q15;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= '0;
      end else if (state_q == ST_MUL) begin
         prod_q <= PW'(mul_a_q) * PW'(mul_b_q);
      end
   end

   // 18-bit sums: -alpha/2 +/- K*beta cannot wrap at this width.
   always_comb begin
      half_c   = SW'(alpha_q) >>> 1;
      m_c      = SW'(prod_q >>> FRAC);
      sum_c.va = SW'(alpha_q);
      sum_c.vb = m_c - half_c;
      sum_c.vc = -half_c - m_c;
   end

`ifdef INV_CLARKE_ZSI_EN
   logic signed [SW-1:0] vzs_c;
   phase18_t             zsi_c;

   always_comb begin
      vzs_c    = zs_offset(sum_q);
      zsi_c.va = sum_q.va + vzs_c;
      zsi_c.vb = sum_q.vb + vzs_c;
      zsi_c.vc = sum_q.vc + vzs_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else if (state_q == ST_SUM) begin
         sum_q <= sum_c;
      end else if (state_q == ST_ZSI) begin
         sum_q <= zsi_c;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else if (state_q == ST_SUM) begin
         sum_q <= sum_c;
      end
   end
`endif

   sat_s18_s16 #(.SAT_LIM(SAT_LIM)) u_sat_a (.x(sum_q.va), .y_c(va_c), .clip_c(clip_c[0]));
   sat_s18_s16 #(.SAT_LIM(SAT_LIM)) u_sat_b (.x(sum_q.vb), .y_c(vb_c), .clip_c(clip_c[1]));
   sat_s18_s16 #(.SAT_LIM(SAT_LIM)) u_sat_c (.x(sum_q.vc), .y_c(vc_c), .clip_c(clip_c[2]));

   // Result registers hold between samples; out_valid pulses once per OUT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         va_q        <= '0;
         vb_q        <= '0;
         vc_q        <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         out_valid_q <= (state_q == ST_OUT);
         in_ready_q  <= (state_d == ST_IDLE);
         if (state_q == ST_OUT) begin
            va_q  <= va_c;
            vb_q  <= vb_c;
            vc_q  <= vc_c;
            sat_q <= |clip_c;
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.va        = va_q;
   assign bus.vb        = vb_q;
   assign bus.vc        = vc_q;
   assign bus.sat       = sat_q;

endmodule

// File: tb/tb_inv_clarke.sv
// Scoreboard bench for inv_clarke: accepts are modelled with plain integer math, a monitor checks results.
module tb_inv_clarke;

`ifdef INV_CLARKE_ZSI_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif
   localparam int LIM = 32767;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   inv_clarke_if bus ();

   inv_clarke #(.SAT_LIM(LIM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int va;
      int vb;
      int vc;
      int sat;
      int acc;
   } exp_t;

   exp_t sbq[$];
   int   acc_cyc[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_acc = -100;
   int   n_out = 0;
   int   hold_va = 0, hold_vb = 0, hold_vc = 0, hold_sat = 0;
   bit   hold_ok;

   function automatic exp_t model(input int a, input int b, input int acc);
      exp_t r;
      int   p[3];
      int   m, half, mx, mn, vz;
      m    = (b * 28378) >>> 15;
      half = a >>> 1;
      p[0] = a;
      p[1] = -half + m;
      p[2] = -half - m;
`ifdef INV_CLARKE_ZSI_EN
      mx = p[0]; mn = p[0];
      for (int i = 1; i < 3; i++) begin
         if (p[i] > mx) mx = p[i];
         if (p[i] < mn) mn = p[i];
      end
      vz = -((mx + mn) >>> 1);
      for (int i = 0; i < 3; i++) p[i] = p[i] + vz;
`else
      mx = 0; mn = 0; vz = 0;
`endif
      r.sat = 0;
      for (int i = 0; i < 3; i++) begin
         if (p[i] > LIM) begin p[i] = LIM; r.sat = 1; end
         else if (p[i] < -LIM) begin p[i] = -LIM; r.sat = 1; end
      end
      r.va = p[0]; r.vb = p[1]; r.vc = p[2]; r.acc = acc;
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Acceptance observer: the edge where in_valid & in_ready meet issues the expected result.
   always @(posedge clk) begin
      cyc++;
      if (rst_n && bus.in_valid && bus.in_ready) begin
         sbq.push_back(model($signed(bus.alpha), $signed(bus.beta), cyc));
         acc_cyc.push_back(cyc);
         last_acc = cyc;
      end
   end

   // Output monitor.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready", int'(bus.in_ready), (cyc - last_acc >= LAT) ? 1 : 0);
         if (bus.out_valid) begin
            n_out++;
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_out_valid actual=1 required=0 (cycle %0d)", cyc);
            end else begin
               mon_e = sbq.pop_front();
               chk("va", $signed(bus.va), mon_e.va);
               chk("vb", $signed(bus.vb), mon_e.vb);
               chk("vc", $signed(bus.vc), mon_e.vc);
               chk("sat", int'(bus.sat), mon_e.sat);
               chk("latency", cyc - mon_e.acc, LAT);
               hold_va = mon_e.va; hold_vb = mon_e.vb; hold_vc = mon_e.vc; hold_sat = mon_e.sat;
            end
         end else begin
            chk("hold_va", $signed(bus.va), hold_va);
            chk("hold_vb", $signed(bus.vb), hold_vb);
            chk("hold_vc", $signed(bus.vc), hold_vc);
            chk("hold_sat", int'(bus.sat), hold_sat);
         end
      end
   end

   task automatic issue(input int a, input int b);
      bit ok;
      int guard;
      guard = 0;
      bus.alpha    = 16'(a);
      bus.beta     = 16'(b);
      bus.in_valid = 1'b1;
      do begin
         ok = bus.in_ready;
         @(posedge clk);
         #1;
         guard++;
      end while (!ok && guard < 20);
      bus.in_valid = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=no_accept required=accept");
      end
   endtask

   task automatic send_const(input int a, input int b, input int eva, input int evb,
                             input int evc, input int esat);
      int k;
      issue(a, b);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!bus.out_valid && k < 12);
      chk("const_out_valid", int'(bus.out_valid), 1);
      chk("const_latency", k - 1, LAT);
      chk("const_va", $signed(bus.va), eva);
      chk("const_vb", $signed(bus.vb), evb);
      chk("const_vc", $signed(bus.vc), evc);
      chk("const_sat", int'(bus.sat), esat);
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (sbq.size() != 0 && g < 40) begin
         @(posedge clk);
         g++;
      end
      @(posedge clk);
      #1;
      chk("drain_empty", sbq.size(), 0);
   endtask

   initial begin
      int a, b, sel, n_before;
      bus.in_valid = 1'b0;
      bus.alpha    = '0;
      bus.beta     = '0;

      #12;
      chk("rst_va", $signed(bus.va), 0);
      chk("rst_vb", $signed(bus.vb), 0);
      chk("rst_vc", $signed(bus.vc), 0);
      chk("rst_sat", int'(bus.sat), 0);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      #5 rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", int'(bus.in_ready), 1);

`ifdef INV_CLARKE_ZSI_EN
      send_const(16384, 0, 12288, -12288, -12288, 0);
`else
      send_const(16384, 0, 16384, -8192, -8192, 0);
      send_const(0, 16384, 0, 14189, -14189, 0);
      send_const(-32768, 32767, -32767, 32767, -11993, 1);
`endif
      drain();

      // Reset while the sample sits in SUM: result abandoned, outputs cleared.
      issue(12345, -2222);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      sbq.delete();
      last_acc = -100;
      hold_va = 0; hold_vb = 0; hold_vc = 0; hold_sat = 0;
      #1;
      chk("midrst_va", $signed(bus.va), 0);
      chk("midrst_vb", $signed(bus.vb), 0);
      chk("midrst_vc", $signed(bus.vc), 0);
      chk("midrst_sat", int'(bus.sat), 0);
      chk("midrst_out_valid", int'(bus.out_valid), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n_before = n_out;
      @(negedge clk);
      chk("midrst_ready", int'(bus.in_ready), 1);
      repeat (8) @(posedge clk);
      #1;
      chk("midrst_no_out", n_out - n_before, 0);

      // in_valid held high with fresh data after every acceptance.
      acc_cyc.delete();
      bus.alpha    = 16'($urandom);
      bus.beta     = 16'($urandom);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 24; i++) begin
         hold_ok = bus.in_ready;
         @(posedge clk);
         #1;
         if (hold_ok) begin
            bus.alpha = 16'($urandom);
            bus.beta  = 16'($urandom);
         end
      end
      bus.in_valid = 1'b0;
      chk("hold_accepts", acc_cyc.size(), (24 + LAT) / (LAT + 1));
      for (int i = 1; i < acc_cyc.size(); i++)
         chk("hold_gap", acc_cyc[i] - acc_cyc[i-1], LAT + 1);
      drain();

      for (int i = 0; i < 200; i++) begin
         sel = int'($urandom_range(0, 7));
         a = (sel == 0) ? -32768 : (sel == 1) ? 32767 : int'($signed(16'($urandom)));
         sel = int'($urandom_range(0, 7));
         b = (sel == 0) ? -32768 : (sel == 1) ? 32767 : int'($signed(16'($urandom)));
         issue(a, b);
         repeat (int'($urandom_range(0, 3))) @(posedge clk);
         #1;
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
